// File: rtl/pipe_stage_buf.sv
// ============================================================================
// pipe_stage_buf : pipeline-boundary register with a 2-entry skid buffer,
//                  bubble-cleared control field and saturating stall counter.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_buf #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_ih;
    logic w_oh;

    // in_ready depends only on registered state, so back-pressure never
    // forms a combinational path from out_ready to in_ready.
    assign in_ready  = !r_skid_valid;
    assign w_ih      = in_valid && in_ready;
    assign w_oh      = r_main_valid && out_ready;

    assign out_valid = r_main_valid;
    assign out_ctrl  = r_main_ctrl & {CTRL_W{r_main_valid}};
    assign out_data  = r_main_data;
    assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            // Payload is left in place; only the side-effect bits are cleared.
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
        end else if (r_skid_valid) begin
            if (w_oh) begin
                r_main_valid <= 1'b1;
                r_main_ctrl  <= r_skid_ctrl;
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end
        end else if (!r_main_valid) begin
            if (w_ih) begin
                r_main_valid <= 1'b1;
                r_main_ctrl  <= in_ctrl;
                r_main_data  <= in_data;
            end
        end else if (w_oh) begin
            if (w_ih) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_ih) begin
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= in_ctrl;
            r_skid_data  <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire
